packet_lane_drain: RTL and testbench



---
 rtl/packet_buffer_pkg.sv | 17 +
 rtl/rr_lane_arbiter.sv | 29 ++
 rtl/packet_lane_drain.sv | 198 +++++++++++++++++++
 tb/tb_packet_lane_drain.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_buffer_pkg.sv
// Shared types and constants for the packet buffer and its lane drain.
package packet_buffer_pkg;

  localparam int unsigned LEN_FIELD_BYTES   = 2;
  localparam int unsigned MAX_PACKET_LENGTH = 1518;
  localparam int unsigned CNT_W             = 8 * LEN_FIELD_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_LEN_HI  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_DROP    = 3'd4,
    ST_LEN_FWD = 3'd5
  } drain_state_t;

endpackage

// File: rtl/rr_lane_arbiter.sv
// Round-robin lane search: first requesting lane after ptr, wrapping mod NUM_LANES.
module rr_lane_arbiter #(
  parameter int unsigned NUM_LANES = 8
) (
  input  logic [NUM_LANES-1:0]         req,
  input  logic [$clog2(NUM_LANES)-1:0] ptr,
  output logic [$clog2(NUM_LANES)-1:0] grant_idx_c,
  output logic                         grant_vld_c
);

  localparam int unsigned LANE_W = $clog2(NUM_LANES);

  logic [LANE_W-1:0] idx;

  always_comb begin
    grant_idx_c = '0;
    grant_vld_c = 1'b0;
    idx         = '0;
    for (int unsigned i = 1; i <= NUM_LANES; i++) begin
      // NUM_LANES is a power of two, so truncation is the modulo wrap
      idx = LANE_W'(32'(ptr) + i);
      if (!grant_vld_c && req[idx]) begin
        grant_vld_c = 1'b1;
        grant_idx_c = idx;
      end
    end
  end

endmodule

// File: rtl/packet_lane_drain.sv
// Serialises length-framed packets from per-lane byte streams onto one AXI4-Stream byte master.
// Optional: PACKET_LANE_DRAIN_FORWARD_LEN_EN also forwards the 2 length bytes ahead of the payload.
module packet_lane_drain
  import packet_buffer_pkg::*;
#(
  parameter int unsigned NUM_LANES         = 8,
  parameter int unsigned DATA_WIDTH        = 8,
  parameter int unsigned MAX_PACKET_LENGTH = packet_buffer_pkg::MAX_PACKET_LENGTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [DATA_WIDTH-1:0]        lane_tdata_i [NUM_LANES],
  input  logic [NUM_LANES-1:0]         lane_tvalid_i,
  output logic [NUM_LANES-1:0]         lane_tready_o,
  output logic [DATA_WIDTH-1:0]        m_tdata_o,
  output logic                         m_tvalid_o,
  output logic                         m_tlast_o,
  input  logic                         m_tready_i,
  output logic [$clog2(NUM_LANES)-1:0] active_lane_o,
  output logic                         drop_o
);

  localparam int unsigned LANE_W = $clog2(NUM_LANES);

  drain_state_t          state_q, state_d;
  logic [LANE_W-1:0]     active_q, active_d;
  logic [LANE_W-1:0]     ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] len_lo_q, len_lo_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  drop_q, drop_d;
`ifdef PACKET_LANE_DRAIN_FORWARD_LEN_EN
  logic [DATA_WIDTH-1:0] len_hi_q, len_hi_d;
`endif

  logic [LANE_W-1:0]     grant_idx;
  logic                  grant_vld;
  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  can_pop;
  logic                  pop;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic [CNT_W-1:0]      len_full;

  rr_lane_arbiter #(
    .NUM_LANES (NUM_LANES)
  ) u_arb (
    .req         (lane_tvalid_i),
    .ptr         (ptr_q),
    .grant_idx_c (grant_idx),
    .grant_vld_c (grant_vld)
  );

  assign sel_valid = lane_tvalid_i[active_q];
  assign sel_data  = lane_tdata_i[active_q];
  assign len_full  = CNT_W'({sel_data, len_lo_q});

  // Discarded bytes never touch the output register, so DROP ignores backpressure
  always_comb begin
    can_pop = 1'b0;
    if (state_q == ST_LEN_LO || state_q == ST_LEN_HI ||
        state_q == ST_PAYLOAD || state_q == ST_DROP) begin
      can_pop = (state_q == ST_DROP) || !tvalid_q || m_tready_i;
    end
    pop = can_pop && sel_valid;
    lane_tready_o = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      lane_tready_o[k] = (LANE_W'(k) == active_q) && can_pop;
    end
  end

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    ptr_d     = ptr_q;
    len_lo_d  = len_lo_q;
    cnt_d     = cnt_q;
    drop_d    = 1'b0;
    load      = 1'b0;
    load_data = '0;
    load_last = 1'b0;
`ifdef PACKET_LANE_DRAIN_FORWARD_LEN_EN
    len_hi_d  = len_hi_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          active_d = grant_idx;
          ptr_d    = grant_idx;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (pop) begin
          len_lo_d = sel_data;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (pop) begin
          cnt_d = len_full;
`ifdef PACKET_LANE_DRAIN_FORWARD_LEN_EN
          len_hi_d = sel_data;
          if (len_full > CNT_W'(MAX_PACKET_LENGTH)) begin
            drop_d  = 1'b1;
            state_d = ST_DROP;
          end else begin
            load      = 1'b1;
            load_data = len_lo_q;
            state_d   = ST_LEN_FWD;
          end
`else
          if (len_full == '0) begin
            state_d = ST_IDLE;
          end else if (len_full > CNT_W'(MAX_PACKET_LENGTH)) begin
            drop_d  = 1'b1;
            state_d = ST_DROP;
          end else begin
            state_d = ST_PAYLOAD;
          end
`endif
        end
      end
`ifdef PACKET_LANE_DRAIN_FORWARD_LEN_EN
      // Second length byte is emitted without a lane pop once the output frees up
      ST_LEN_FWD: begin
        if (!tvalid_q || m_tready_i) begin
          load      = 1'b1;
          load_data = len_hi_q;
          load_last = (cnt_q == '0);
          state_d   = (cnt_q == '0) ? ST_IDLE : ST_PAYLOAD;
        end
      end
`endif
      ST_PAYLOAD: begin
        if (pop) begin
          load      = 1'b1;
          load_data = sel_data;
          load_last = (cnt_q == CNT_W'(1));
          cnt_d     = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (pop) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tvalid_d = load ? 1'b1 : (m_tready_i ? 1'b0 : tvalid_q);
    tdata_d  = load ? load_data : tdata_q;
    tlast_d  = load ? load_last : tlast_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      active_q <= '0;
      ptr_q    <= LANE_W'(NUM_LANES - 1);
      len_lo_q <= '0;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      drop_q   <= 1'b0;
`ifdef PACKET_LANE_DRAIN_FORWARD_LEN_EN
      len_hi_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      ptr_q    <= ptr_d;
      len_lo_q <= len_lo_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      drop_q   <= drop_d;
`ifdef PACKET_LANE_DRAIN_FORWARD_LEN_EN
      len_hi_q <= len_hi_d;
`endif
    end
  end

  assign m_tdata_o     = tdata_q;
  assign m_tvalid_o    = tvalid_q;
  assign m_tlast_o     = tlast_q;
  assign active_lane_o = active_q;
  assign drop_o        = drop_q;

endmodule

// File: tb/tb_packet_lane_drain.sv
// Self-checking bench for packet_lane_drain: directed and randomized packets against a round-robin packet model.
module tb_packet_lane_drain;

  localparam int unsigned NL   = 8;
  localparam int unsigned MAXL = 1518;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [2:0] lane;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] lane_tdata_i [NL];
  logic [NL-1:0] lane_tvalid_i = '0;
  logic [NL-1:0] lane_tready_o;
  logic [7:0] m_tdata_o;
  logic       m_tvalid_o;
  logic       m_tlast_o;
  logic       m_tready_i = 1'b0;
  logic [2:0] active_lane_o;
  logic       drop_o;

  packet_lane_drain dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .lane_tdata_i  (lane_tdata_i),
    .lane_tvalid_i (lane_tvalid_i),
    .lane_tready_o (lane_tready_o),
    .m_tdata_o     (m_tdata_o),
    .m_tvalid_o    (m_tvalid_o),
    .m_tlast_o     (m_tlast_o),
    .m_tready_i    (m_tready_i),
    .active_lane_o (active_lane_o),
    .drop_o        (drop_o)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0] lane_q  [NL][$];
  int         pkt_len [NL][$];
  logic [7:0] pkt_pay [NL][$];
  exp_t       exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mptr = NL - 1;
  int exp_drops = 0;
  int drops_seen = 0;
  int xfer_n = 0, xfer_first = 0, xfer_last = 0;
  int rdy_mode = 0;  // 0: always ready, 1: toggle, 2: random
  bit gap_en = 1'b0;

  task automatic drive();
    for (int k = 0; k < NL; k++) begin
      lane_tvalid_i[k] = (lane_q[k].size() != 0) && !(gap_en && $urandom_range(0, 2) == 0);
      lane_tdata_i[k]  = (lane_q[k].size() != 0) ? lane_q[k][0] : 8'h00;
    end
    case (rdy_mode)
      0: m_tready_i = 1'b1;
      1: m_tready_i = ~m_tready_i;
      default: m_tready_i = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic tick();
    logic [NL-1:0] popm;
    exp_t e;
    @(negedge clk_i);
    cyc++;
    if (m_tvalid_o && m_tready_i) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++; $error("FAIL unexpected_out observed %02h expected no output", m_tdata_o);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (m_tdata_o === e.d) else begin
          errors++; $error("FAIL tdata observed %02h expected %02h", m_tdata_o, e.d);
        end
        checks++;
        assert (m_tlast_o === e.l) else begin
          errors++; $error("FAIL tlast observed %0b expected %0b", m_tlast_o, e.l);
        end
        if (!e.l) begin
          checks++;
          assert (active_lane_o === e.lane) else begin
            errors++; $error("FAIL active_lane observed %0d expected %0d", active_lane_o, e.lane);
          end
        end
      end
      if (xfer_n == 0) xfer_first = cyc;
      xfer_last = cyc;
      xfer_n++;
    end
    if (drop_o === 1'b1) drops_seen++;
    checks++;
    assert ($onehot0(lane_tready_o)) else begin
      errors++; $error("FAIL tready_onehot observed %b expected at most one bit", lane_tready_o);
    end
    if (m_tvalid_o && !m_tready_i) begin
      checks++;
      assert (lane_tready_o === '0) else begin
        errors++; $error("FAIL pop_while_held observed %b expected 0", lane_tready_o);
      end
    end
    popm = lane_tvalid_i & lane_tready_o;
    @(posedge clk_i);
    #1;
    for (int k = 0; k < NL; k++)
      if (popm[k]) void'(lane_q[k].pop_front());
    drive();
  endtask

  task automatic add_pkt(input int lane, input int len);
    logic [7:0] b;
    lane_q[lane].push_back(8'(len));
    lane_q[lane].push_back(8'(len >> 8));
    for (int j = 0; j < len; j++) begin
      b = 8'($urandom);
      lane_q[lane].push_back(b);
      pkt_pay[lane].push_back(b);
    end
    pkt_len[lane].push_back(len);
  endtask

  task automatic add_bytes(input int lane, input int len, input logic [7:0] first);
    logic [7:0] b;
    lane_q[lane].push_back(8'(len));
    lane_q[lane].push_back(8'(len >> 8));
    for (int j = 0; j < len; j++) begin
      b = first + 8'(j);
      lane_q[lane].push_back(b);
      pkt_pay[lane].push_back(b);
    end
    pkt_len[lane].push_back(len);
  endtask

  // Round-robin over whole packets: next lane after the last served one that still has a packet
  task automatic model_build();
    int sel, len;
    bit found;
    logic [7:0] b;
    exp_t e;
    forever begin
      found = 1'b0;
      sel = 0;
      for (int i = 1; i <= NL; i++) begin
        if (!found && pkt_len[(mptr + i) % NL].size() != 0) begin
          found = 1'b1;
          sel = (mptr + i) % NL;
        end
      end
      if (!found) break;
      mptr = sel;
      len = pkt_len[sel].pop_front();
      if (len > MAXL) exp_drops++;
      for (int j = 0; j < len; j++) begin
        b = pkt_pay[sel].pop_front();
        if (len <= MAXL) begin
          e.d = b; e.l = (j == len - 1); e.lane = 3'(sel);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  function automatic bit busy();
    bit any = (exp_q.size() != 0) || m_tvalid_o;
    for (int k = 0; k < NL; k++) if (lane_q[k].size() != 0) any = 1'b1;
    return any;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n = 0;
    model_build();
    drive();
    while (busy() && n < budget) begin
      tick();
      n++;
    end
    repeat (4) tick();
    checks++;
    assert (n < budget) else begin
      errors++; $error("FAIL %s_timeout observed %0d cycles expected < %0d", tag, n, budget);
    end
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++; $error("FAIL %s_missing observed %0d bytes left expected 0", tag, exp_q.size());
    end
    checks++;
    assert (drops_seen == exp_drops) else begin
      errors++; $error("FAIL %s_drops observed %0d expected %0d", tag, drops_seen, exp_drops);
    end
    drops_seen = 0;
    exp_drops = 0;
  endtask

  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    checks++;
    assert (lane_tready_o === '0) else begin
      errors++; $error("FAIL %s_tready observed %b expected 0", tag, lane_tready_o);
    end
    checks++;
    assert (m_tvalid_o === 1'b0) else begin
      errors++; $error("FAIL %s_tvalid observed %b expected 0", tag, m_tvalid_o);
    end
    checks++;
    assert (m_tlast_o === 1'b0) else begin
      errors++; $error("FAIL %s_tlast observed %b expected 0", tag, m_tlast_o);
    end
    checks++;
    assert (m_tdata_o === 8'h00) else begin
      errors++; $error("FAIL %s_tdata observed %02h expected 00", tag, m_tdata_o);
    end
    checks++;
    assert (active_lane_o === 3'd0) else begin
      errors++; $error("FAIL %s_active observed %0d expected 0", tag, active_lane_o);
    end
    checks++;
    assert (drop_o === 1'b0) else begin
      errors++; $error("FAIL %s_drop observed %b expected 0", tag, drop_o);
    end
    for (int k = 0; k < NL; k++) begin
      lane_q[k].delete();
      pkt_len[k].delete();
      pkt_pay[k].delete();
    end
    exp_q.delete();
    mptr = NL - 1;
    drive();
    rst_i = 1'b0;
  endtask

  initial begin
    int len, n;
    for (int k = 0; k < NL; k++) lane_tdata_i[k] = 8'h00;
    repeat (2) @(posedge clk_i);
    #1;
    do_reset("reset");

    // Lane 2 alone: payload A1..A5 back to back
    rdy_mode = 0;
    xfer_n = 0;
    add_bytes(2, 5, 8'hA1);
    drain("lane2", 200);
    checks++;
    assert (xfer_n == 5 && xfer_last - xfer_first == 4) else begin
      errors++; $error("FAIL lane2_burst observed %0d bytes over %0d cycles expected 5 over 4", xfer_n, xfer_last - xfer_first);
    end

    // Two lanes competing: order follows round-robin
    add_bytes(0, 3, 8'h10);
    add_bytes(0, 3, 8'h30);
    add_bytes(1, 3, 8'h20);
    drain("rr", 400);

    // Oversize packet dropped, next one delivered
    add_pkt(3, 16'h0600);
    add_pkt(3, 7);
    drain("drop", 4000);

    // Boundary lengths: max legal, one over, zero
    add_pkt(6, MAXL);
    add_pkt(7, MAXL + 1);
    add_pkt(1, 0);
    add_pkt(1, 2);
    drain("bound", 8000);

    // Backpressure toggling on a 4-byte payload
    rdy_mode = 1;
    add_bytes(4, 4, 8'hC0);
    drain("toggle", 400);

    // Lane valid gaps on a single lane
    rdy_mode = 0;
    gap_en = 1'b1;
    add_pkt(4, 12);
    add_pkt(4, 5);
    drain("gaps", 600);
    gap_en = 1'b0;

    // Reset mid-payload, then a fresh packet on lane 0
    add_pkt(5, 20);
    model_build();
    drive();
    n = 0;
    while (lane_q[5].size() > 10 && n < 200) begin
      tick();
      n++;
    end
    do_reset("midrst");
    add_pkt(0, 6);
    drain("postrst", 400);

    // Randomized traffic over all lanes with random backpressure
    rdy_mode = 2;
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < 6; p++) begin
        case ($urandom_range(0, 9))
          0: len = 0;
          1: len = MAXL + 1 + int'($urandom_range(0, 40));
          default: len = int'($urandom_range(1, 40));
        endcase
        add_pkt(int'($urandom_range(0, NL - 1)), len);
      end
      drain("rand", 20000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
